mc_sequencer: RTL and testbench

//  Multi-cycle control FSM for the MIPS datapath (ifetch/idecode/exe/dmem blocks).

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/mc_seq_decode.sv | 30 +++
 rtl/mc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct codes, FSM states and PC-source encodings
package mips_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_src_e;

    typedef enum logic [3:0] {
        C_ALU     = 4'd0,
        C_LOAD    = 4'd1,
        C_STORE   = 4'd2,
        C_BRANCH  = 4'd3,
        C_JUMP    = 4'd4,
        C_JAL     = 4'd5,
        C_JR      = 4'd6,
        C_SYSCALL = 4'd7,
        C_ILLEGAL = 4'd8
    } ins_class_e;

endpackage

// File: rtl/mc_seq_decode.sv
// rtl/mc_seq_decode.sv - combinational instruction classifier from op_code/function_code
module mc_seq_decode
    import mips_pkg::*;
(
    input  logic [5:0] op_code_i,
    input  logic [5:0] function_code_i,
    output ins_class_e cls_o
);

    always_comb begin
        cls_o = C_ILLEGAL;
        case (op_code_i)
            OP_RTYPE: begin
                case (function_code_i)
                    FN_JR:      cls_o = C_JR;
                    FN_SYSCALL: cls_o = C_SYSCALL;
                    default:    cls_o = C_ALU;
                endcase
            end
            OP_J:     cls_o = C_JUMP;
            OP_JAL:   cls_o = C_JAL;
            OP_BEQ, OP_BNE: cls_o = C_BRANCH;
            OP_LW:    cls_o = C_LOAD;
            OP_SW:    cls_o = C_STORE;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls_o = C_ALU;
            default:  cls_o = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle MIPS control FSM; MC_SEQ_PERF_EN adds cycle/instruction counters
module mc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op_code,
    input  logic [5:0]       function_code,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic             illegal,
    output logic             mem_err,
`ifdef MC_SEQ_PERF_EN
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ins_cnt,
`endif
    output logic [2:0]       state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_err_q, mem_err_d;
    ins_class_e cls;

    logic    ir_we_c, pc_we_c, reg_we_c, mem_req_c, mem_we_c, halted_c, illegal_c;
    pc_src_e pc_src_c;

    mc_seq_decode u_decode (
        .op_code_i       (op_code),
        .function_code_i (function_code),
        .cls_o           (cls)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            wait_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        ir_we_c   = 1'b0;
        pc_we_c   = 1'b0;
        pc_src_c  = PC_PLUS4;
        reg_we_c  = 1'b0;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        halted_c  = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_IF: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (cls)
                    C_JUMP: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_JUMP;
                        state_d  = S_IF;
                    end
                    C_JAL: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_JUMP;
                        reg_we_c = 1'b1;
                        state_d  = S_IF;
                    end
                    C_JR: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_JR;
                        state_d  = S_IF;
                    end
                    C_SYSCALL: state_d = S_HALT;
                    C_ILLEGAL: begin
                        illegal_c = 1'b1;
                        state_d   = S_IF;
                    end
                    default:   state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cls)
                    C_BRANCH: begin
                        pc_we_c  = branch_taken;
                        pc_src_c = PC_BRANCH;
                        state_d  = S_IF;
                    end
                    C_LOAD, C_STORE: begin
                        wait_d  = 8'd0;
                        state_d = S_MEM;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (cls == C_STORE);
                // A ready arriving on the last allowed cycle still completes normally.
                if (mem_ready) begin
                    wait_d  = 8'd0;
                    state_d = (cls == C_STORE) ? S_IF : S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d    = 8'd0;
                    mem_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                state_d  = S_IF;
            end
            S_HALT: begin
                halted_c = 1'b1;
                if (resume) state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Outputs are forced low while reset is held so an in-flight dmem request drops at once.
    assign ir_we   = rst & ir_we_c;
    assign pc_we   = rst & pc_we_c;
    assign pc_src  = rst ? pc_src_c : 2'd0;
    assign reg_we  = rst & reg_we_c;
    assign mem_req = rst & mem_req_c;
    assign mem_we  = rst & mem_we_c;
    assign halted  = rst & halted_c;
    assign illegal = rst & illegal_c;
    assign mem_err = mem_err_q;
    assign state   = state_q;

`ifdef MC_SEQ_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] cyc_q, ins_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state_q != S_HALT) cyc_q <= cyc_q + CNT_ONE;
            if (state_d == S_IF && state_q != S_IF) ins_q <= ins_q + CNT_ONE;
        end
    end

    assign cyc_cnt = cyc_q;
    assign ins_cnt = ins_q;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - directed self-checking bench for mc_sequencer
module tb_mc_sequencer;

    localparam int CNT_W = 32;

    // {ir_we, pc_we, pc_src[1:0], reg_we, mem_req, mem_we, halted, illegal}
    localparam logic [8:0] F_NONE = 9'b0_0_00_0_0_0_0_0;
    localparam logic [8:0] F_IF   = 9'b1_1_00_0_0_0_0_0;
    localparam logic [8:0] F_WB   = 9'b0_0_00_1_0_0_0_0;
    localparam logic [8:0] F_MEMR = 9'b0_0_00_0_1_0_0_0;
    localparam logic [8:0] F_MEMW = 9'b0_0_00_0_1_1_0_0;
    localparam logic [8:0] F_BRT  = 9'b0_1_01_0_0_0_0_0;
    localparam logic [8:0] F_BRN  = 9'b0_0_01_0_0_0_0_0;
    localparam logic [8:0] F_J    = 9'b0_1_10_0_0_0_0_0;
    localparam logic [8:0] F_JAL  = 9'b0_1_10_1_0_0_0_0;
    localparam logic [8:0] F_JR   = 9'b0_1_11_0_0_0_0_0;
    localparam logic [8:0] F_HALT = 9'b0_0_00_0_0_0_1_0;
    localparam logic [8:0] F_ILL  = 9'b0_0_00_0_0_0_0_1;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       op_code, function_code;
    logic             branch_taken, mem_ready, resume;
    logic             ir_we, pc_we, reg_we, mem_req, mem_we, halted, illegal, mem_err;
    logic [1:0]       pc_src;
    logic [2:0]       state;
`ifdef MC_SEQ_PERF_EN
    logic [CNT_W-1:0] cyc_cnt, ins_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    mc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_code       (op_code),
        .function_code (function_code),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .resume        (resume),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .reg_we        (reg_we),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .halted        (halted),
        .illegal       (illegal),
        .mem_err       (mem_err),
`ifdef MC_SEQ_PERF_EN
        .cyc_cnt       (cyc_cnt),
        .ins_cnt       (ins_cnt),
`endif
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [2:0] st, input logic [8:0] f, input logic me);
        logic [12:0] got, exp;
        #1;
        got = {state, ir_we, pc_we, pc_src, reg_we, mem_req, mem_we, halted, illegal, mem_err};
        exp = {st, f, me};
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input logic [8:0] f, input logic me);
        expect_out(tag, st, f, me);
        step();
    endtask

    initial begin
        rst = 1'b0; op_code = 6'h00; function_code = 6'h00;
        branch_taken = 1'b0; mem_ready = 1'b0; resume = 1'b0;
        #3;
        expect_out("reset", 3'd0, F_NONE, 1'b0);
`ifdef MC_SEQ_PERF_EN
        check("reset_cyc", cyc_cnt, 32'd0);
        check("reset_ins", ins_cnt, 32'd0);
`endif
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;

        // add: IF ID EX WB, mem_ready unknown and unused
        op_code = 6'h00; function_code = 6'h20; mem_ready = 1'bx;
        cyc("add_if", 3'd0, F_IF, 1'b0);
        cyc("add_id", 3'd1, F_NONE, 1'b0);
        cyc("add_ex", 3'd2, F_NONE, 1'b0);
        cyc("add_wb", 3'd4, F_WB, 1'b0);
`ifdef MC_SEQ_PERF_EN
        #1;
        check("perf_cyc", cyc_cnt, 32'd4);
        check("perf_ins", ins_cnt, 32'd1);
`endif

        // lw: ready arrives on the 4th MEM cycle, same cycle as the timeout boundary
        op_code = 6'h23; mem_ready = 1'b0;
        cyc("lw_if", 3'd0, F_IF, 1'b0);
        cyc("lw_id", 3'd1, F_NONE, 1'b0);
        cyc("lw_ex", 3'd2, F_NONE, 1'b0);
        cyc("lw_mem1", 3'd3, F_MEMR, 1'b0);
        cyc("lw_mem2", 3'd3, F_MEMR, 1'b0);
        cyc("lw_mem3", 3'd3, F_MEMR, 1'b0);
        mem_ready = 1'b1;
        cyc("lw_mem4", 3'd3, F_MEMR, 1'b0);
        mem_ready = 1'b0;
        cyc("lw_wb", 3'd4, F_WB, 1'b0);

        // beq taken, bne not taken
        op_code = 6'h04; branch_taken = 1'b1;
        cyc("beq_if", 3'd0, F_IF, 1'b0);
        cyc("beq_id", 3'd1, F_NONE, 1'b0);
        cyc("beq_ex", 3'd2, F_BRT, 1'b0);
        op_code = 6'h05; branch_taken = 1'b0;
        cyc("bne_if", 3'd0, F_IF, 1'b0);
        cyc("bne_id", 3'd1, F_NONE, 1'b0);
        cyc("bne_ex", 3'd2, F_BRN, 1'b0);

        // jumps complete in ID
        op_code = 6'h02;
        cyc("j_if", 3'd0, F_IF, 1'b0);
        cyc("j_id", 3'd1, F_J, 1'b0);
        op_code = 6'h03;
        cyc("jal_if", 3'd0, F_IF, 1'b0);
        cyc("jal_id", 3'd1, F_JAL, 1'b0);
        op_code = 6'h00; function_code = 6'h08;
        cyc("jr_if", 3'd0, F_IF, 1'b0);
        cyc("jr_id", 3'd1, F_JR, 1'b0);

        // sw with mem_ready stuck low; resume pulsed outside HALT is ignored
        op_code = 6'h2B; resume = 1'b1;
        cyc("sw_if", 3'd0, F_IF, 1'b0);
        resume = 1'b0;
        cyc("sw_id", 3'd1, F_NONE, 1'b0);
        cyc("sw_ex", 3'd2, F_NONE, 1'b0);
        cyc("sw_mem1", 3'd3, F_MEMW, 1'b0);
        cyc("sw_mem2", 3'd3, F_MEMW, 1'b0);
        cyc("sw_mem3", 3'd3, F_MEMW, 1'b0);
        cyc("sw_mem4", 3'd3, F_MEMW, 1'b0);
        cyc("sw_halt1", 3'd5, F_HALT, 1'b1);
        cyc("sw_halt2", 3'd5, F_HALT, 1'b1);
        resume = 1'b1;
        cyc("sw_halt_res", 3'd5, F_HALT, 1'b1);
        resume = 1'b0;

        // syscall halts, then an illegal opcode pulses illegal and acts as a nop
        op_code = 6'h00; function_code = 6'h0C;
        cyc("sys_if", 3'd0, F_IF, 1'b1);
        cyc("sys_id", 3'd1, F_NONE, 1'b1);
        resume = 1'b1;
        cyc("sys_halt", 3'd5, F_HALT, 1'b1);
        resume = 1'b0;
        op_code = 6'h3F;
        cyc("ill_if", 3'd0, F_IF, 1'b1);
        cyc("ill_id", 3'd1, F_ILL, 1'b1);
        cyc("ill_back", 3'd0, F_IF, 1'b1);

        // reset asserted mid-MEM
        op_code = 6'h23;
        cyc("rlw_id", 3'd1, F_NONE, 1'b1);
        cyc("rlw_ex", 3'd2, F_NONE, 1'b1);
        expect_out("rlw_mem", 3'd3, F_MEMR, 1'b1);
        rst = 1'b0;
        expect_out("rst_in_mem", 3'd0, F_NONE, 1'b0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
`ifdef MC_SEQ_PERF_EN
        check("rst_cyc", cyc_cnt, 32'd0);
        check("rst_ins", ins_cnt, 32'd0);
`endif
        @(negedge clk); rst = 1'b1;
        expect_out("rst_release", 3'd0, F_IF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
